// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - ID-stage conditional branch resolution with operand wait and statistics
//
// Purpose: detects a one-hot branch class in ID, stalls IF/ID until the
// operands are available, latches them, and resolves the branch one cycle
// later, issuing a one-cycle PC redirect (and IF flush) when taken.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   id_valid, id_is_branch    ID instruction valid, one-hot branch class
//                             [0] beq [1] bne [2] blez [3] bgtz [4] bltz [5] bgez
//   id_override_rt, id_rt_val decoder-supplied substitute for rt
//   rs_val, rt_val            forwarded operands
//   rs_ready, rt_ready        operand availability
//   id_target                 branch target address
//   stall                     hold IF/ID this cycle
//   redirect, flush           one-cycle PC redirect / IF flush
//   redirect_pc               new PC while redirect=1, else 0
//   br_cnt, taken_cnt         resolved / taken branch counters (wrap)
//
// Configuration macro: BRANCH_DELAY_SLOT_EN
//   defined   - flush held at 0, the delay-slot instruction executes
//   undefined - flush mirrors redirect

module branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_is_branch,
    input  logic             id_override_rt,
    input  logic [31:0]      id_rt_val,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic [31:0]      id_target,
    output logic             stall,
    output logic             redirect,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  cls_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;
    logic [31:0] target_q;
    logic [31:0] idrt_q;
    logic        ovr_q;

    logic        is_onehot;
    logic        branch_present;
    logic        ready_id;
    logic        ready_wait;
    logic        rs_zero;
    logic        rs_neg;
    logic        taken;

    // x & (x-1) clears the lowest set bit; zero result with nonzero x means one-hot
    assign is_onehot      = (id_is_branch != 6'd0) &&
                            ((id_is_branch & (id_is_branch - 6'd1)) == 6'd0);
    assign branch_present = id_valid && is_onehot;

    // In IDLE the override comes straight from ID; once in WAIT the latched
    // override decides whether rt_ready matters.
    assign ready_id   = rs_ready && (rt_ready || id_override_rt);
    assign ready_wait = rs_ready && (rt_ready || ovr_q);

    assign rs_zero = (rs_q == 32'd0);
    assign rs_neg  = rs_q[31];

    always_comb begin
        taken = 1'b0;
        unique case (1'b1)
            cls_q[0]: taken = (rs_q == rt_q);
            cls_q[1]: taken = (rs_q != rt_q);
            cls_q[2]: taken = rs_neg || rs_zero;
            cls_q[3]: taken = !rs_neg && !rs_zero;
            cls_q[4]: taken = rs_neg;
            cls_q[5]: taken = !rs_neg;
            default:  taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cls_q     <= 6'd0;
            rs_q      <= 32'd0;
            rt_q      <= 32'd0;
            target_q  <= 32'd0;
            idrt_q    <= 32'd0;
            ovr_q     <= 1'b0;
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_present) begin
                        // Class, target and rt substitute are frozen here; only
                        // the forwarded operands are sampled again from WAIT.
                        cls_q    <= id_is_branch;
                        target_q <= id_target;
                        ovr_q    <= id_override_rt;
                        idrt_q   <= id_rt_val;
                        if (ready_id) begin
                            rs_q  <= rs_val;
                            rt_q  <= id_override_rt ? id_rt_val : rt_val;
                            state <= EVAL;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (ready_wait) begin
                        rs_q  <= rs_val;
                        rt_q  <= ovr_q ? idrt_q : rt_val;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    br_cnt <= br_cnt + CNT_W'(1);
                    if (taken) begin
                        taken_cnt <= taken_cnt + CNT_W'(1);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // rst gating keeps stall low while reset is held, even with a branch in ID
    assign stall       = !rst && (((state == IDLE) && branch_present) || (state == WAIT));
    assign redirect    = !rst && (state == EVAL) && taken;
    assign redirect_pc = redirect ? target_q : 32'd0;

`ifdef BRANCH_DELAY_SLOT_EN
    assign flush = 1'b0;
`else
    assign flush = redirect;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl (vector table, hand sequences, random)

module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [5:0]  id_is_branch;
    logic        id_override_rt;
    logic [31:0] id_rt_val;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rs_ready;
    logic        rt_ready;
    logic [31:0] id_target;

    logic        stall, redirect, flush;
    logic [31:0] redirect_pc;
    logic [15:0] br_cnt, taken_cnt;

    logic        s_stall, s_redirect, s_flush;
    logic [31:0] s_redirect_pc;
    logic [1:0]  s_br_cnt, s_taken_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int mdl_br    = 0;
    int mdl_taken = 0;

    always #5 clk = ~clk;

    branch_ctrl u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_override_rt(id_override_rt), .id_rt_val(id_rt_val),
        .rs_val(rs_val), .rt_val(rt_val), .rs_ready(rs_ready), .rt_ready(rt_ready),
        .id_target(id_target), .stall(stall), .redirect(redirect), .flush(flush),
        .redirect_pc(redirect_pc), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    branch_ctrl #(.CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_override_rt(id_override_rt), .id_rt_val(id_rt_val),
        .rs_val(rs_val), .rt_val(rt_val), .rs_ready(rs_ready), .rt_ready(rt_ready),
        .id_target(id_target), .stall(s_stall), .redirect(s_redirect), .flush(s_flush),
        .redirect_pc(s_redirect_pc), .br_cnt(s_br_cnt), .taken_cnt(s_taken_cnt)
    );

    typedef struct {
        string       name;
        int          cls;
        logic [31:0] rs;
        logic [31:0] rt;
        bit          ovr;
        logic [31:0] idrt;
        bit          rt_rdy;
        logic [31:0] tgt;
        int          waits;
        bit          exp_taken;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Branch outcome straight from the architectural rules on signed integers
    function automatic bit model_taken(input int cls, input logic [31:0] rs, input logic [31:0] rt);
        int s;
        s = rs;
        case (cls)
            0: return rs == rt;
            1: return rs != rt;
            2: return s <= 0;
            3: return s > 0;
            4: return s < 0;
            default: return s >= 0;
        endcase
    endfunction

    function automatic bit exp_flush(input bit red);
`ifdef BRANCH_DELAY_SLOT_EN
        return 1'b0;
`else
        return red;
`endif
    endfunction

    task automatic check_cnts(input string name);
        check({name, " br_cnt"},      32'(br_cnt),      32'(mdl_br    % 65536));
        check({name, " taken_cnt"},   32'(taken_cnt),   32'(mdl_taken % 65536));
        check({name, " s_br_cnt"},    32'(s_br_cnt),    32'(mdl_br    % 4));
        check({name, " s_taken_cnt"}, 32'(s_taken_cnt), 32'(mdl_taken % 4));
    endtask

    // Drives one branch, holding rs_ready low for 'waits' cycles, then checks
    // the resolve cycle and the counters afterwards. Called at posedge+1 in IDLE.
    task automatic run_branch(input string name, input int cls, input logic [31:0] rs,
                              input logic [31:0] rt, input bit ovr, input logic [31:0] idrt,
                              input bit rt_rdy, input logic [31:0] tgt, input int waits,
                              input bit exp_tk);
        id_valid       = 1'b1;
        id_is_branch   = 6'(1 << cls);
        rs_val         = rs;
        rt_val         = rt;
        id_override_rt = ovr;
        id_rt_val      = idrt;
        rt_ready       = rt_rdy;
        id_target      = tgt;
        for (int c = 0; c <= waits; c++) begin
            rs_ready = (c == waits);
            #1;
            check({name, " stall"}, 32'(stall), 32'd1);
            check({name, " early redirect"}, 32'(redirect), 32'd0);
            tick();
        end
        id_valid     = 1'b0;
        id_is_branch = 6'd0;
        rs_ready     = 1'b0;
        #1;
        check({name, " eval stall"}, 32'(stall), 32'd0);
        check({name, " redirect"}, 32'(redirect), 32'(exp_tk));
        check({name, " redirect_pc"}, redirect_pc, exp_tk ? tgt : 32'd0);
        check({name, " flush"}, 32'(flush), 32'(exp_flush(exp_tk)));
        mdl_br++;
        if (exp_tk) mdl_taken++;
        tick();
        check({name, " idle redirect"}, 32'(redirect), 32'd0);
        check_cnts(name);
    endtask

    task automatic non_branch(input string name, input logic [5:0] cls);
        id_valid     = 1'b1;
        id_is_branch = cls;
        rs_ready     = 1'b1;
        rt_ready     = 1'b1;
        #1;
        check({name, " stall"}, 32'(stall), 32'd0);
        tick();
        check({name, " redirect"}, 32'(redirect), 32'd0);
        check_cnts(name);
        id_valid     = 1'b0;
        id_is_branch = 6'd0;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 2)) - 32'd1;
            1: begin
                case ($urandom_range(0, 2))
                    0: return 32'h8000_0000;
                    1: return 32'h7FFF_FFFF;
                    default: return 32'hFFFF_FFFF;
                endcase
            end
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back('{"beq_eq",     0, 32'd5,          32'd5, 0, 32'd0, 1, 32'h400,  0, 1});
        vecs.push_back('{"bne_eq",     1, 32'd7,          32'd7, 0, 32'd0, 1, 32'h500,  0, 0});
        vecs.push_back('{"bltz_wait3", 4, 32'hFFFF_FFFF,  32'd0, 0, 32'd0, 1, 32'h600,  3, 1});
        vecs.push_back('{"blez_max",   2, 32'h7FFF_FFFF,  32'd0, 0, 32'd0, 1, 32'h700,  0, 0});
        vecs.push_back('{"beq_ovr",    0, 32'd9,          32'd3, 1, 32'd9, 0, 32'h800,  0, 1});
        vecs.push_back('{"bgtz_zero",  3, 32'd0,          32'd0, 0, 32'd0, 1, 32'h900,  0, 0});
        vecs.push_back('{"bgtz_one",   3, 32'd1,          32'd0, 0, 32'd0, 1, 32'hA00,  1, 1});
        vecs.push_back('{"bgez_zero",  5, 32'd0,          32'd0, 0, 32'd0, 1, 32'hB00,  0, 1});
        vecs.push_back('{"bltz_zero",  4, 32'd0,          32'd0, 0, 32'd0, 1, 32'hC00,  0, 0});
        vecs.push_back('{"blez_zero",  2, 32'd0,          32'd0, 0, 32'd0, 1, 32'hD00,  0, 1});
        vecs.push_back('{"blez_min",   2, 32'h8000_0000,  32'd0, 0, 32'd0, 1, 32'hE00,  0, 1});
        vecs.push_back('{"bne_wait2",  1, 32'd1,          32'd2, 0, 32'd0, 1, 32'hF00,  2, 1});
        vecs.push_back('{"bgez_min",   5, 32'h8000_0000,  32'd0, 0, 32'd0, 1, 32'h1000, 0, 0});

        // Reset with a ready branch in ID: outputs must stay quiet
        rst = 1'b1;
        id_valid = 1'b1; id_is_branch = 6'b000001; id_override_rt = 1'b0;
        id_rt_val = 32'd0; rs_val = 32'd5; rt_val = 32'd5;
        rs_ready = 1'b1; rt_ready = 1'b1; id_target = 32'h400;
        #2;
        check("reset stall", 32'(stall), 32'd0);
        check("reset redirect", 32'(redirect), 32'd0);
        check("reset flush", 32'(flush), 32'd0);
        check("reset redirect_pc", redirect_pc, 32'd0);
        check_cnts("reset");
        tick();
        id_valid = 1'b0; id_is_branch = 6'd0;
        rst = 1'b0;
        tick();

        foreach (vecs[i])
            run_branch(vecs[i].name, vecs[i].cls, vecs[i].rs, vecs[i].rt, vecs[i].ovr,
                       vecs[i].idrt, vecs[i].rt_rdy, vecs[i].tgt, vecs[i].waits,
                       vecs[i].exp_taken);

        non_branch("multi_hot", 6'b000011);
        non_branch("zero_class", 6'b000000);

        // New branch presented during EVAL is only picked up in the next IDLE
        id_valid = 1'b1; id_is_branch = 6'b000001; id_override_rt = 1'b0;
        rs_val = 32'd3; rt_val = 32'd3; rs_ready = 1'b1; rt_ready = 1'b1; id_target = 32'h1234;
        #1;
        check("b2b first stall", 32'(stall), 32'd1);
        tick();
        id_is_branch = 6'b000010; rs_val = 32'd4; rt_val = 32'd4; id_target = 32'h5678;
        #1;
        check("b2b eval stall", 32'(stall), 32'd0);
        check("b2b first redirect_pc", redirect_pc, 32'h1234);
        mdl_br++; mdl_taken++;
        tick();
        check("b2b second stall", 32'(stall), 32'd1);
        check("b2b idle redirect", 32'(redirect), 32'd0);
        tick();
        id_valid = 1'b0; id_is_branch = 6'd0;
        #1;
        check("b2b second redirect", 32'(redirect), 32'd0);
        mdl_br++;
        tick();
        check_cnts("b2b");

        // Reset while in WAIT drops the branch
        id_valid = 1'b1; id_is_branch = 6'b010000; rs_val = 32'hFFFF_FFFF;
        rs_ready = 1'b0; id_target = 32'h2000;
        #1;
        check("rstwait stall idle", 32'(stall), 32'd1);
        tick();
        check("rstwait stall wait", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        check("rstwait stall", 32'(stall), 32'd0);
        check("rstwait redirect", 32'(redirect), 32'd0);
        mdl_br = 0; mdl_taken = 0;
        check_cnts("rstwait");
        tick();
        rst = 1'b0; id_valid = 1'b0; id_is_branch = 6'd0; rs_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rstwait post redirect", 32'(redirect), 32'd0);
            tick();
        end
        check_cnts("rstwait post");

        // Narrow counters wrap: five taken branches leave taken_cnt=1
        for (int k = 0; k < 5; k++)
            run_branch("wrap", 0, 32'(k), 32'(k), 0, 32'd0, 1, 32'h3000 + 32'(k), 0, 1);
        check("cnt_w2 taken after 5", 32'(s_taken_cnt), 32'd1);

        // Random branches against the rule-level model
        for (int n = 0; n < 200; n++) begin
            int          cls;
            logic [31:0] rs, rt, idrt, tgt;
            bit          ovr, rtr;
            int          w;
            cls  = $urandom_range(0, 5);
            rs   = rand_word();
            rt   = ($urandom_range(0, 1) == 1) ? rs : rand_word();
            ovr  = $urandom_range(0, 3) == 0;
            idrt = ($urandom_range(0, 1) == 1) ? rs : rand_word();
            rtr  = ovr ? 1'($urandom_range(0, 1)) : 1'b1;
            tgt  = $urandom & 32'hFFFF_FFFC;
            w    = $urandom_range(0, 3);
            run_branch("rand", cls, rs, rt, ovr, idrt, rtr, tgt, w,
                       model_taken(cls, rs, ovr ? idrt : rt));
            if ($urandom_range(0, 7) == 0) begin
                logic [5:0] bad;
                bad = 6'($urandom_range(0, 63));
                if ($countones(bad) == 1) bad = bad | 6'b100000 | 6'b000001;
                non_branch("rand_nonbranch", bad);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
